mem_scan_ctrl: RTL and testbench

//   Parametrised raster-scan sequencer for the memory copy path. On start it

---
 rtl/mem_scan_pkg.sv | 16 +
 rtl/scan_delay_line.sv | 40 ++++
 rtl/mem_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_scan_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_scan_pkg.sv
// Shared types and default sizing for the raster-scan memory copy sequencer.
package mem_scan_pkg;

  localparam int ROW_W_DEF = 8;
  localparam int COL_W_DEF = 8;
  localparam int LAT_DEF   = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } scan_state_t;

endpackage

// File: rtl/scan_delay_line.sv
// Fixed-depth shift register of {valid,data} words with enable and synchronous flush.
// The valid flag is the MSB of each word.
module scan_delay_line #(
  parameter int W     = 17,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] in_word,
  output logic [W-1:0] out_word
);

  logic [W-1:0] word_q [DEPTH];
  logic [W-1:0] word_d [DEPTH];

  always_comb begin
    word_d = word_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) word_d[i] = '0;
    end else if (en) begin
      word_d[0] = in_word;
      for (int i = 1; i < DEPTH; i++) word_d[i] = word_q[i-1];
    end
  end

  // NOTE: every stage is reset, data included, so the valid bits start clear
  // and the write address never carries X out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) word_q[i] <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign out_word = word_q[DEPTH-1];

endmodule

// File: rtl/mem_scan_ctrl.sv
// Raster-scan sequencer: activates the array, reads a rows x cols window column-fastest,
// and replays each read address as a write address LAT un-stalled cycles later.
module mem_scan_ctrl
  import mem_scan_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             abort,
  input  logic [ROW_W-1:0] last_row,
  input  logic [COL_W-1:0] last_col,
  output logic             act,
  output logic             rd,
  output logic             wr,
  output logic [ROW_W-1:0] addr_row_r,
  output logic [COL_W-1:0] addr_col_r,
  output logic [ROW_W-1:0] addr_row_w,
  output logic [COL_W-1:0] addr_col_w,
  output logic             busy,
  output logic             done
);

  localparam int PIPE_W = ROW_W + COL_W + 1;
  localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LAT - 1);

  scan_state_t      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, lrow_q, lrow_d, wrow_q, wrow_d;
  logic [COL_W-1:0] col_q, col_d, lcol_q, lcol_d, wcol_q, wcol_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              active, hold;
  logic [PIPE_W-1:0] pipe_out;
  logic              pipe_vld;
  logic [ROW_W-1:0]  pipe_row;
  logic [COL_W-1:0]  pipe_col;

  assign active = (state_q == S_PRIME) || (state_q == S_READ) || (state_q == S_DRAIN);
  // Stall only freezes the working states; abort always takes effect.
  assign hold   = stall && active && !abort;

  assign {pipe_vld, pipe_row, pipe_col} = pipe_out;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lrow_d  = lrow_q;
    lcol_d  = lcol_q;
    cnt_d   = cnt_q;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;

    if (pipe_vld) begin
      wrow_d = pipe_row;
      wcol_d = pipe_col;
    end

    if (abort) begin
      state_d = S_IDLE;
    end else if (!hold) begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_PRIME;
          lrow_d  = last_row;
          lcol_d  = last_col;
        end
        S_PRIME: begin
          // Counters clear here so the read address holds its old value through PRIME.
          state_d = S_READ;
          row_d   = '0;
          col_d   = '0;
        end
        S_READ: begin
          if (col_q == lcol_q) begin
            if (row_q == lrow_q) begin
              state_d = S_DRAIN;
              cnt_d   = '0;
            end else begin
              row_d = row_q + 1'b1;
              col_d = '0;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        // The last read enters the pipe as DRAIN begins; it emerges LAT-1 cycles in.
        S_DRAIN: begin
          if (cnt_q == DRAIN_LAST) state_d = S_DONE;
          else                     cnt_d   = cnt_q + 1'b1;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      lrow_q  <= '0;
      lcol_q  <= '0;
      cnt_q   <= '0;
      wrow_q  <= '0;
      wcol_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lrow_q  <= lrow_d;
      lcol_q  <= lcol_d;
      cnt_q   <= cnt_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
    end
  end

  scan_delay_line #(
    .W     (PIPE_W),
    .DEPTH (LAT)
  ) u_wr_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (!hold),
    .flush    (abort),
    .in_word  ({state_q == S_READ, row_q, col_q}),
    .out_word (pipe_out)
  );

  assign act        = active;
  assign busy       = active;
  assign rd         = (state_q == S_READ);
  assign done       = (state_q == S_DONE);
  assign wr         = pipe_vld;
  assign addr_row_r = row_q;
  assign addr_col_r = col_q;
  assign addr_row_w = pipe_vld ? pipe_row : wrow_q;
  assign addr_col_w = pipe_vld ? pipe_col : wcol_q;

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Scoreboard bench for mem_scan_ctrl: expected read addresses come from a raster model,
// and each expected read is queued for its write replay LAT un-stalled cycles later.
module tb_mem_scan_ctrl;

  localparam int ROW_W = 8;
  localparam int COL_W = 8;
  localparam int LAT   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0, stall = 1'b0, abort = 1'b0;
  logic [ROW_W-1:0] last_row = '0;
  logic [COL_W-1:0] last_col = '0;
  logic             act, rd, wr, busy, done;
  logic [ROW_W-1:0] addr_row_r, addr_row_w;
  logic [COL_W-1:0] addr_col_r, addr_col_w;

  typedef struct {
    logic [15:0] a;
    int          u;
  } wr_ent_t;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_scan_ctrl #(.ROW_W(ROW_W), .COL_W(COL_W), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stall      (stall),
    .abort      (abort),
    .last_row   (last_row),
    .last_col   (last_col),
    .act        (act),
    .rd         (rd),
    .wr         (wr),
    .addr_row_r (addr_row_r),
    .addr_col_r (addr_col_r),
    .addr_row_w (addr_row_w),
    .addr_col_w (addr_col_w),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered at a falling edge while the DUT is idle; that cycle is cycle 0.
  task automatic run_scan(input logic [7:0] lr, input logic [7:0] lc, input int stall_at,
                          input int stall_len, input int abort_at, input bit poke_start);
    logic [15:0] rd_q[$];
    wr_ent_t     wr_q[$];
    wr_ent_t     we;
    logic [15:0] exp_a, last_r, last_w;
    int          beats, cyc, u, done_cyc, n_rd;
    bit          stall_prev, aborted;

    beats = (int'(lr) + 1) * (int'(lc) + 1);
    for (int r = 0; r <= int'(lr); r++)
      for (int c = 0; c <= int'(lc); c++)
        rd_q.push_back({r[7:0], c[7:0]});
    cyc = 0; u = 0; done_cyc = -1; n_rd = 0;
    last_r = '0; last_w = '0; aborted = 1'b0;

    start = 1'b1; last_row = lr; last_col = lc; stall = 1'b0; abort = 1'b0;

    forever begin
      stall_prev = stall;
      @(negedge clk);
      cyc++;
      if (!stall_prev) u++;
      aborted = (abort_at >= 0) && (cyc > abort_at);

      if (cyc == 1) begin
        check("prime_act", act, 1);
        check("prime_busy", busy, 1);
        check("prime_rd", rd, 0);
      end

      if (aborted) begin
        if (cyc == abort_at + 1)
          check("abort_outs", {act, rd, wr, busy}, 4'b0000);
        check("abort_no_done", done, 0);
        check("abort_no_wr", wr, 0);
      end else begin
        if (rd) begin
          if (!stall_prev) begin
            if (rd_q.size() == 0) begin
              check("rd_extra", rd, 0);
            end else begin
              exp_a = rd_q.pop_front();
              check("rd_addr", {addr_row_r, addr_col_r}, exp_a);
              last_r = exp_a;
              n_rd++;
              wr_q.push_back('{a: exp_a, u: u});
            end
          end else begin
            check("rd_hold", {addr_row_r, addr_col_r}, last_r);
          end
        end else if (n_rd > 0) begin
          check("rd_addr_idle_hold", {addr_row_r, addr_col_r}, last_r);
        end

        if (wr) begin
          if (!stall_prev) begin
            if (wr_q.size() == 0) begin
              check("wr_extra", wr, 0);
            end else begin
              we = wr_q.pop_front();
              check("wr_addr", {addr_row_w, addr_col_w}, we.a);
              check("wr_gap", u - we.u, LAT);
              last_w = we.a;
            end
          end else begin
            check("wr_hold", {addr_row_w, addr_col_w}, last_w);
          end
        end

        if (done && done_cyc < 0) begin
          done_cyc = cyc;
          check("done_busy", busy, 0);
          check("done_act", act, 0);
        end
      end

      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        check("done_pulse_len", done, 0);
        check("idle_busy", busy, 0);
        break;
      end
      if (abort_at >= 0 && cyc == abort_at + LAT + 4) break;
      if (cyc > 2000) begin
        check("timeout", 1, 0);
        break;
      end

      stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      abort = (cyc == abort_at);
      if (poke_start && cyc >= 4 && cyc <= 6) begin
        start = 1'b1; last_row = 8'h05; last_col = 8'h05;
      end else begin
        start = 1'b0;
      end
    end

    stall = 1'b0; abort = 1'b0; start = 1'b0;
    if (abort_at >= 0) begin
      check("abort_done_cycle", done_cyc, -1);
    end else begin
      check("done_cycle", done_cyc, 2 + beats + LAT + stall_len);
      check("rd_count", n_rd, beats);
      check("rd_q_empty", rd_q.size(), 0);
      check("wr_q_empty", wr_q.size(), 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {act, rd, wr, busy, done}, 5'b0);
    check("reset_addr", {addr_row_r, addr_col_r, addr_row_w, addr_col_w}, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {act, busy}, 2'b00);

    // Reset asserted mid-READ clears outputs without waiting for a clock.
    start = 1'b1; last_row = 8'd3; last_col = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_read_rd", rd, 1);
    #2 rst = 1'b0;
    #1 check("async_reset_outs", {act, rd, wr, busy, done}, 5'b0);
    check("async_reset_addr", {addr_row_r, addr_col_r, addr_row_w, addr_col_w}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("stays_idle", {act, rd, busy}, 3'b000);

    // Abort together with start in IDLE keeps the block idle.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", busy, 0);
    @(negedge clk);
    check("abort_start_idle2", busy, 0);

    run_scan(8'd3, 8'd3, -1, 0, -1, 1'b0);  // full 4x4 scan
    run_scan(8'd2, 8'd2, -1, 0, -1, 1'b0);  // column wrap at 2
    run_scan(8'd3, 8'd3,  6, 3, -1, 1'b0);  // 3-cycle stall mid-READ
    run_scan(8'd1, 8'd1, -1, 0,  8, 1'b0);  // abort in DRAIN
    run_scan(8'd1, 8'd2, -1, 0, -1, 1'b0);  // clean restart after abort
    run_scan(8'd0, 8'd0, -1, 0, -1, 1'b1);  // 1x1 window, start pokes while busy

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
